muldiv_unit: RTL and testbench

- Parametrised multi-cycle M-extension execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the CPU core.
- Generalises the core's fixed 32-bit, radix-2 divide path with these additions:
  - configurable width and radix (bits retired per cycle);
  - configurable multiplier pipeline depth;
  - single-cycle fast path for divide special cases;
  - explicit start/done handshake and a kill input for pipeline flushes.
- Sits beside the base ALU; the decoder steers M-ops here and stalls on O_busy.

---
 rtl/aludefs_pkg.sv | 35 +++
 rtl/muldiv_div_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aludefs_pkg.sv
// ---------------------------------------------------------------------------
// aludefs: shared definitions for the M-extension multiply/divide unit.
//   - MD_MUL..MD_REMU : funct3 encodings of the eight M-ops
//   - MD_ST_*         : muldiv_unit FSM state encodings. The state names carry
//                       an _ST_ infix so MD_MUL (opcode) and the multiply state
//                       can coexist in one namespace.
//   - helper functions to classify an opcode.
// ---------------------------------------------------------------------------
package aludefs;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [1:0] MD_ST_IDLE = 2'd0;
   localparam logic [1:0] MD_ST_MUL  = 2'd1;
   localparam logic [1:0] MD_ST_DIV  = 2'd2;
   localparam logic [1:0] MD_ST_FIX  = 2'd3;

   // All divide/remainder ops have funct3[2] set.
   function automatic logic md_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // Only DIV and REM treat their operands as two's complement.
   function automatic logic md_div_signed(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step: combinational radix-2^DIV_BITS restoring division step.
// Shifts DIV_BITS dividend bits (MSB first) into the partial remainder,
// subtracting the divisor whenever it fits.
//   rem_in   in  XLEN      partial remainder (always < divisor)
//   divisor  in  XLEN      divisor magnitude
//   dvd_bits in  DIV_BITS  next dividend bits, MSB first
//   rem_out  out XLEN      updated partial remainder
//   quo_bits out DIV_BITS  quotient bits produced by this step
// ---------------------------------------------------------------------------
module muldiv_div_step
   import aludefs::*;
#(
   parameter int XLEN     = 32,
   parameter int DIV_BITS = 1
) (
   input  logic [XLEN-1:0]     rem_in,
   input  logic [XLEN-1:0]     divisor,
   input  logic [DIV_BITS-1:0] dvd_bits,
   output logic [XLEN-1:0]     rem_out,
   output logic [DIV_BITS-1:0] quo_bits
);

   // One extra bit: the shifted remainder can momentarily reach 2*divisor-1.
   logic [XLEN:0] r;

   always_comb begin
      r        = {1'b0, rem_in};
      quo_bits = '0;
      for (int i = DIV_BITS - 1; i >= 0; i--) begin
         r = {r[XLEN-1:0], dvd_bits[i]};
         if (r >= {1'b0, divisor}) begin
            r           = r - {1'b0, divisor};
            quo_bits[i] = 1'b1;
         end
      end
      rem_out = r[XLEN-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit: multi-cycle RISC-V M-extension execution unit.
// Multiplies go through a MUL_LATENCY-deep product path; divides run a
// restoring divider retiring DIV_BITS quotient bits per cycle on operand
// magnitudes, with signs applied in the final FIX state. Divide-by-zero and
// signed overflow skip the iteration and finish in one cycle.
//   I_clk     in  1     clock
//   I_reset   in  1     synchronous active-high reset
//   I_start   in  1     accept an op (ignored unless idle, or while I_kill)
//   I_op      in  3     funct3 of the M-op
//   I_dataS1  in  XLEN  rs1, captured on the accept edge
//   I_dataS2  in  XLEN  rs2, captured on the accept edge
//   I_kill    in  1     abort the in-flight op without a result
//   O_busy    out 1     op in flight, including the O_done cycle
//   O_done    out 1     single-cycle result strobe
//   O_data    out XLEN  last completed result
// ---------------------------------------------------------------------------
module muldiv_unit
   import aludefs::*;
#(
   parameter int XLEN        = 32,
   parameter int DIV_BITS    = 1,
   parameter int MUL_LATENCY = 1
) (
   input  logic            I_clk,
   input  logic            I_reset,
   input  logic            I_start,
   input  logic [2:0]      I_op,
   input  logic [XLEN-1:0] I_dataS1,
   input  logic [XLEN-1:0] I_dataS2,
   input  logic            I_kill,
   output logic            O_busy,
   output logic            O_done,
   output logic [XLEN-1:0] O_data
);

   localparam int ITER     = XLEN / DIV_BITS;
   localparam int CNT_W    = $clog2(ITER + 1);
   localparam int MUL_PIPE = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
   localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
   localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // Captured operation. dvd_q/dsr_q hold raw operands for multiplies and
   // magnitudes for divides; dvd_q becomes the quotient as it shifts.
   logic [2:0]      op_q;
   logic            spc_q, qneg_q, rneg_q;
   logic [XLEN-1:0] fix_q, dvd_q, dsr_q, rem_q;

   // Input-side decode
   logic            in_signed, s1_neg, s2_neg, div_zero, div_ovf, in_special;
   logic [XLEN-1:0] s1_mag, s2_mag, spc_val;

   always_comb begin
      in_signed  = md_div_signed(I_op);
      s1_neg     = in_signed & I_dataS1[XLEN-1];
      s2_neg     = in_signed & I_dataS2[XLEN-1];
      s1_mag     = s1_neg ? -I_dataS1 : I_dataS1;
      s2_mag     = s2_neg ? -I_dataS2 : I_dataS2;
      div_zero   = (I_dataS2 == '0);
      div_ovf    = in_signed && (I_dataS1 == MOST_NEG) && (I_dataS2 == '1);
      in_special = md_is_div(I_op) && (div_zero || div_ovf);
      // funct3[1] separates REM/REMU from DIV/DIVU.
      if (div_zero)
         spc_val = I_op[1] ? I_dataS1 : '1;
      else
         spc_val = I_op[1] ? '0 : I_dataS1;
   end

   assign accept = (state == MD_ST_IDLE) && I_start && !I_kill;
   assign O_busy = (state != MD_ST_IDLE) || O_done;

   // Multiply: operands extended to full product width so one unsigned
   // multiply yields the correct low 2*XLEN bits for every sign mix.
   logic                     a_sgn, b_sgn;
   logic signed [2*XLEN-1:0] mul_a, mul_b, mul_full;
   logic [2*XLEN-1:0]        prod_c, prod_fin;
   logic [2*XLEN-1:0]        prod_p [MUL_PIPE];

   always_comb begin
      a_sgn    = (op_q == MD_MUL) || (op_q == MD_MULH) || (op_q == MD_MULHSU);
      b_sgn    = (op_q == MD_MUL) || (op_q == MD_MULH);
      mul_a    = {{XLEN{a_sgn & dvd_q[XLEN-1]}}, dvd_q};
      mul_b    = {{XLEN{b_sgn & dsr_q[XLEN-1]}}, dsr_q};
      mul_full = mul_a * mul_b;
      prod_c   = mul_full;
   end

   // Product pipeline stage boundary: free-running shift chain, the FSM
   // counter decides when the tail holds the product of the current op.
   always_ff @(posedge I_clk) begin
      prod_p[0] <= prod_c;
      for (int k = 1; k < MUL_PIPE; k++)
         prod_p[k] <= prod_p[k-1];
   end

   assign prod_fin = (MUL_LATENCY == 1) ? prod_c : prod_p[MUL_PIPE-1];

   // Divide iteration
   logic [XLEN-1:0]     step_rem;
   logic [DIV_BITS-1:0] step_q;

   muldiv_div_step #(
      .XLEN     (XLEN),
      .DIV_BITS (DIV_BITS)
   ) u_step (
      .rem_in   (rem_q),
      .divisor  (dsr_q),
      .dvd_bits (dvd_q[XLEN-1 -: DIV_BITS]),
      .rem_out  (step_rem),
      .quo_bits (step_q)
   );

   // Datapath registers: no reset, qualified by accept / DIV state.
   always_ff @(posedge I_clk) begin
      if (accept) begin
         op_q   <= I_op;
         spc_q  <= in_special;
         fix_q  <= spc_val;
         qneg_q <= s1_neg ^ s2_neg;
         rneg_q <= s1_neg;
         rem_q  <= '0;
         dvd_q  <= s1_mag;
         dsr_q  <= md_is_div(I_op) ? s2_mag : I_dataS2;
      end else if (state == MD_ST_DIV) begin
         rem_q <= step_rem;
         dvd_q <= {dvd_q[XLEN-DIV_BITS-1:0], step_q};
      end
   end

   // Result selection and sign fix-up
   logic [XLEN-1:0] quo_fin, rem_fin, result;

   always_comb begin
      quo_fin = qneg_q ? -dvd_q : dvd_q;
      rem_fin = rneg_q ? -rem_q : rem_q;
      case (op_q)
         MD_MUL:                        result = prod_fin[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fin[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               result = spc_q ? fix_q : quo_fin;
         default:                       result = spc_q ? fix_q : rem_fin;
      endcase
   end

   // Control FSM. Priority: reset, then kill, then normal progress.
   always_ff @(posedge I_clk) begin
      if (I_reset) begin
         state  <= MD_ST_IDLE;
         cnt    <= '0;
         O_done <= 1'b0;
         O_data <= '0;
      end else begin
         O_done <= 1'b0;
         if ((state != MD_ST_IDLE) && I_kill) begin
            state <= MD_ST_IDLE;
         end else begin
            case (state)
               MD_ST_IDLE: begin
                  if (accept) begin
                     cnt <= '0;
                     if (md_is_div(I_op))
                        state <= in_special ? MD_ST_FIX : MD_ST_DIV;
                     else
                        state <= (MUL_LATENCY == 1) ? MD_ST_FIX : MD_ST_MUL;
                  end
               end
               MD_ST_MUL: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == MUL_LAST) state <= MD_ST_FIX;
               end
               MD_ST_DIV: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == ITER_LAST) state <= MD_ST_FIX;
               end
               default: begin
                  state  <= MD_ST_IDLE;
                  O_done <= 1'b1;
                  O_data <= result;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit: two instances of muldiv_unit
//   dut0: XLEN=32, DIV_BITS=1, MUL_LATENCY=1
//   dut1: XLEN=32, DIV_BITS=4, MUL_LATENCY=3
// A transaction-level model (accept -> result after a fixed latency, with
// kill/reset dropping the op) predicts O_busy/O_done/O_data every cycle.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        start [2];
   logic        kill  [2];
   logic [2:0]  op    [2];
   logic [31:0] s1    [2];
   logic [31:0] s2    [2];
   logic        busy  [2];
   logic        done  [2];
   logic [31:0] data  [2];

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] last_exp [2];

   muldiv_unit #(.XLEN(32), .DIV_BITS(1), .MUL_LATENCY(1)) u_dut0 (
      .I_clk(clk), .I_reset(rst[0]), .I_start(start[0]), .I_op(op[0]),
      .I_dataS1(s1[0]), .I_dataS2(s2[0]), .I_kill(kill[0]),
      .O_busy(busy[0]), .O_done(done[0]), .O_data(data[0]));

   muldiv_unit #(.XLEN(32), .DIV_BITS(4), .MUL_LATENCY(3)) u_dut1 (
      .I_clk(clk), .I_reset(rst[1]), .I_start(start[1]), .I_op(op[1]),
      .I_dataS1(s1[1]), .I_dataS2(s2[1]), .I_kill(kill[1]),
      .O_busy(busy[1]), .O_done(done[1]), .O_data(data[1]));

   function automatic void check(string name, int d, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h, want %h (t=%0t)", name, d, act, exp, $time);
      end
   endfunction

   // Reference result from the ISA definition using 64-bit arithmetic.
   function automatic logic [31:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b);
      longint     sa, sb, ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (o)
         OP_MUL:    begin p = sa * sb; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFFFFFF;
            return a / b;
         end
         OP_REM: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b);
      int ml = (d == 0) ? 1 : 3;
      int db = (d == 0) ? 1 : 4;
      if (o < 3'd4) return ml;
      if (b == 0) return 1;
      if ((o == OP_DIV || o == OP_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 32 / db + 1;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h80000000;
         2:       return 32'hFFFFFFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_ok = 1'b0;
   bit          m_busy [2];
   bit          m_done [2];
   int          m_cnt  [2];
   logic [31:0] m_res  [2];
   logic [31:0] m_data [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_data[d] = 32'd0;
            if (d == 0) m_ok = 1'b1;
         end else if (m_busy[d] && kill[d]) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0;
         end else if (m_busy[d]) begin
            m_cnt[d]--;
            m_done[d] = (m_cnt[d] == 0);
            if (m_cnt[d] == 0) begin
               m_busy[d] = 1'b0;
               m_data[d] = m_res[d];
            end
         end else begin
            m_done[d] = 1'b0;
            if (start[d] && !kill[d]) begin
               m_busy[d] = 1'b1;
               m_cnt[d]  = exp_lat(d, op[d], s1[d], s2[d]);
               m_res[d]  = ref_res(op[d], s1[d], s2[d]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         for (int d = 0; d < 2; d++) begin
            check("busy", d, 32'(busy[d]), 32'(m_busy[d] | m_done[d]));
            check("done", d, 32'(done[d]), 32'(m_done[d]));
            check("data", d, data[d], m_data[d]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Call between edges; returns one time step after the accept edge with
   // the operand inputs scrambled.
   task automatic issue(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b);
      start[d] = 1'b1; op[d] = o; s1[d] = a; s2[d] = b;
      @(posedge clk); #1;
      start[d] = 1'b0; op[d] = 3'($urandom_range(0, 7)); s1[d] = $urandom; s2[d] = $urandom;
   endtask

   task automatic wait_done(int d, output int lat);
      lat = 0;
      while (lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (done[d]) break;
      end
      check("done_seen", d, 32'(done[d]), 32'd1);
   endtask

   task automatic count_done(int d, int cycles, output int nd);
      nd = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done[d]) nd++;
      end
   endtask

   task automatic run_dir(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp, int elat);
      int l;
      issue(d, o, a, b);
      wait_done(d, l);
      check("dir_lat", d, 32'(l), 32'(elat));
      check("dir_data", d, data[d], exp);
      check("model_pin", d, ref_res(o, a, b), exp);
      last_exp[d] = exp;
      @(posedge clk); #1;
   endtask

   task automatic dir_both(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp, int lat0, int lat1);
      run_dir(0, o, a, b, exp, lat0);
      run_dir(1, o, a, b, exp, lat1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nd, l;
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; kill[d] = 1'b0;
         op[d] = 3'd0; s1[d] = 32'd0; s2[d] = 32'd0; last_exp[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_busy", d, 32'(busy[d]), 32'd0);
         check("rst_done", d, 32'(done[d]), 32'd0);
         check("rst_data", d, data[d], 32'd0);
         rst[d] = 1'b0;
      end

      dir_both(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 9);
      dir_both(OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33, 9);
      dir_both(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 9);
      dir_both(OP_DIVU,   32'h12345678, 32'd0,        32'hFFFFFFFF, 1, 1);
      dir_both(OP_REMU,   32'h12345678, 32'd0,        32'h12345678, 1, 1);
      dir_both(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
      dir_both(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);
      dir_both(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1, 3);
      dir_both(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3);
      dir_both(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 3);
      dir_both(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 3);
      dir_both(OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 9);

      // Kill at divide iteration 10
      issue(0, OP_DIV, 32'd1000, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      kill[0] = 1'b1;
      @(posedge clk); #1;
      kill[0] = 1'b0;
      check("kill_busy", 0, 32'(busy[0]), 32'd0);
      check("kill_done", 0, 32'(done[0]), 32'd0);
      check("kill_data", 0, data[0], last_exp[0]);
      count_done(0, 40, nd);
      check("kill_nodone", 0, 32'(nd), 32'd0);
      run_dir(0, OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Kill in the multiply pipeline
      issue(1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      kill[1] = 1'b1;
      @(posedge clk); #1;
      kill[1] = 1'b0;
      check("killmul_busy", 1, 32'(busy[1]), 32'd0);
      count_done(1, 10, nd);
      check("killmul_nodone", 1, 32'(nd), 32'd0);

      // Reset mid-divide
      issue(0, OP_DIV, 32'hFFFF0000, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      check("rstmid_busy", 0, 32'(busy[0]), 32'd0);
      check("rstmid_data", 0, data[0], 32'd0);
      count_done(0, 40, nd);
      check("rstmid_nodone", 0, 32'(nd), 32'd0);

      // Kill together with start while idle: start ignored
      start[0] = 1'b1; kill[0] = 1'b1; op[0] = OP_DIVU; s1[0] = 32'd5; s2[0] = 32'd0;
      @(posedge clk); #1;
      start[0] = 1'b0; kill[0] = 1'b0;
      check("killstart_busy", 0, 32'(busy[0]), 32'd0);
      count_done(0, 3, nd);
      check("killstart_nodone", 0, 32'(nd), 32'd0);

      // Start hammered while busy: ignored, exactly one result
      issue(0, OP_DIVU, 32'hFFFFFFFF, 32'h10);
      nd = 0;
      for (int c = 0; c < 60; c++) begin
         if (done[0]) begin nd++; break; end
         start[0] = 1'b1; op[0] = 3'($urandom_range(0, 7)); s1[0] = $urandom; s2[0] = $urandom;
         @(posedge clk); #1;
      end
      start[0] = 1'b0;
      check("hammer_data", 0, data[0], 32'h0FFFFFFF);
      count_done(0, 40, nd);
      check("hammer_onedone", 0, 32'(nd), 32'd0);

      // Back-to-back: second start sits in the O_done cycle
      issue(1, OP_DIV, 32'd7, 32'hFFFFFFFE);
      wait_done(1, l);
      check("b2b_first", 1, data[1], 32'hFFFFFFFD);
      issue(1, OP_REMU, 32'h12345678, 32'd0);
      wait_done(1, l);
      check("b2b_lat", 1, 32'(l), 32'd1);
      check("b2b_second", 1, data[1], 32'h12345678);
      @(posedge clk); #1;

      // Random divides on the radix-16 instance, some back-to-back
      for (int i = 0; i < 1000; i++) begin
         o = OP_DIV + 3'($urandom_range(0, 3));
         a = rnd_opnd(); b = rnd_opnd();
         issue(1, o, a, b);
         wait_done(1, l);
         check("rnd_lat", 1, 32'(l), 32'(exp_lat(1, o, a, b)));
         if ($urandom_range(0, 3) != 0) begin @(posedge clk); #1; end
      end

      // Random mixed ops on both instances
      for (int i = 0; i < 300; i++) begin
         int d = i % 2;
         o = 3'($urandom_range(0, 7));
         a = rnd_opnd(); b = rnd_opnd();
         issue(d, o, a, b);
         wait_done(d, l);
         check("mix_lat", d, 32'(l), 32'(exp_lat(d, o, a, b)));
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
